flash_frame_reader: RTL



---
 rtl/flash_pkg.sv | 13 +
 rtl/flash_addr_gen.sv | 52 +++++
 rtl/flash_frame_reader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared types and address helpers for the flash frame reader.
package flash_pkg;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP, S_OUT} state_t;

  // Address sums are formed this many bits wider than the bus, then truncated.
  localparam int ADDR_GUARD = 2;

  function automatic int win_size(int x0, int x1, int y0, int y1);
    return (x1 - x0) * (y1 - y0);
  endfunction

endpackage

// File: rtl/flash_addr_gen.sv
// Combinational flash byte address for the current (col,row), picking the
// background image or an overlay image inside the window.
module flash_addr_gen
  import flash_pkg::*;
#(
  parameter int H_BYTES   = 1280,
  parameter int V_LINES   = 480,
  parameter int ADDR_W    = 22,
  parameter int NUM_MODES = 4,
  parameter int WIN_X0    = 160,
  parameter int WIN_X1    = 480,
  parameter int WIN_Y0    = 160,
  parameter int WIN_Y1    = 320,
  parameter logic [ADDR_W-1:0] ALT_BASE = 22'h200000,
  parameter int CW        = 11,
  parameter int RW        = 9
) (
  input  logic [CW-1:0]     i_col,
  input  logic [RW-1:0]     i_row,
  input  logic [3:0]        i_mode,
  input  logic              i_alt,
  output logic [ADDR_W-1:0] o_addr
);

  localparam int EW    = ADDR_W + ADDR_GUARD;
  localparam int WSIZE = win_size(WIN_X0, WIN_X1, WIN_Y0, WIN_Y1);

  logic          in_win;
  logic          use_ovl;
  logic [EW-1:0] base;
  logic [EW-1:0] full;
  logic [ADDR_GUARD-1:0] unused_hi;

  always_comb begin
    in_win  = (int'(i_col) >= WIN_X0) && (int'(i_col) < WIN_X1) &&
              (int'(i_row) >= WIN_Y0) && (int'(i_row) < WIN_Y1);
    use_ovl = (int'(i_mode) >= 1) && (int'(i_mode) <= NUM_MODES) && in_win;
    base    = i_alt ? EW'(ALT_BASE) : '0;
    if (use_ovl) begin
      full = base + EW'(H_BYTES * V_LINES)
           + EW'(int'(i_mode) - 1) * EW'(WSIZE)
           + (EW'(i_row) - EW'(WIN_Y0)) * EW'(WIN_X1 - WIN_X0)
           + EW'(i_col) - EW'(WIN_X0);
    end else begin
      full = base + EW'(i_row) * EW'(H_BYTES) + EW'(i_col);
    end
  end

  assign o_addr    = full[ADDR_W-1:0];
  assign unused_hi = full[EW-1:ADDR_W];

endmodule

// File: rtl/flash_frame_reader.sv
// Streams a frame out of parallel NOR flash as BPW-byte words with a
// valid/ready handshake, optionally overlaying a windowed image.
//   state  | meaning
//   S_IDLE | frame boundary; latch mode/alt/en, start when latched en is set
//   S_WAIT | address held for flash access time
//   S_CAP  | sample flash byte, advance column/row
//   S_OUT  | word presented until accepted
module flash_frame_reader
  import flash_pkg::*;
#(
  parameter int H_BYTES   = 1280,
  parameter int V_LINES   = 480,
  parameter int BPW       = 2,
  parameter int ADDR_W    = 22,
  parameter int WAIT_CYC  = 1,
  parameter int NUM_MODES = 4,
  parameter int WIN_X0    = 160,
  parameter int WIN_X1    = 480,
  parameter int WIN_Y0    = 160,
  parameter int WIN_Y1    = 320,
  parameter logic [ADDR_W-1:0] ALT_BASE = 22'h200000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [3:0]        i_mode,
  input  logic              i_alt,
  input  logic [7:0]        i_fdata,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_ce_n,
  output logic              o_oe_n,
  output logic              o_we_n,
  output logic              o_rst_n,
  output logic              o_wp,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [8*BPW-1:0]  o_data,
  output logic              o_sof,
  output logic              o_eol
);

  localparam int CW  = $clog2(H_BYTES + 1);
  localparam int RW  = $clog2(V_LINES + 1);
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [2:0] WLOAD = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;
  localparam state_t NXT_BYTE = (WAIT_CYC == 0) ? S_CAP : S_WAIT;

  state_t           state_q;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [BIW-1:0]   byte_q;
  logic [2:0]       wait_q;
  logic [8*BPW-1:0] shift_q, shift_d, data_q;
  logic             valid_q, sof_q, eol_q, sof_pend_q, fend_q;
  logic [3:0]       mode_q;
  logic             alt_q, en_q;
  logic             line_end, frame_last, last_byte;

  always_comb begin
    line_end   = (col_q == CW'(H_BYTES - 1));
    frame_last = line_end && (row_q == RW'(V_LINES - 1));
    last_byte  = (byte_q == BIW'(BPW - 1));
    col_d      = line_end ? '0 : col_q + CW'(1);
    row_d      = frame_last ? '0 : (line_end ? row_q + RW'(1) : row_q);
    shift_d    = (shift_q << 8) | (8*BPW)'(i_fdata);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      byte_q     <= '0;
      wait_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      sof_pend_q <= 1'b1;
      fend_q     <= 1'b0;
      mode_q     <= '0;
      alt_q      <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          col_q      <= '0;
          row_q      <= '0;
          byte_q     <= '0;
          sof_pend_q <= 1'b1;
          // Selections stay frozen once a frame is armed.
          if (en_q) begin
            state_q <= NXT_BYTE;
            wait_q  <= WLOAD;
          end else begin
            mode_q <= i_mode;
            alt_q  <= i_alt;
            en_q   <= i_en;
          end
        end
        S_WAIT: begin
          if (wait_q == 3'd0) state_q <= S_CAP;
          else                wait_q  <= wait_q - 3'd1;
        end
        S_CAP: begin
          shift_q <= shift_d;
          col_q   <= col_d;
          row_q   <= row_d;
          if (last_byte) begin
            byte_q  <= '0;
            data_q  <= shift_d;
            valid_q <= 1'b1;
            sof_q   <= sof_pend_q;
            eol_q   <= line_end;
            fend_q  <= frame_last;
            state_q <= S_OUT;
          end else begin
            byte_q  <= byte_q + BIW'(1);
            wait_q  <= WLOAD;
            state_q <= NXT_BYTE;
          end
        end
        S_OUT: begin
          if (i_ready) begin
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            sof_pend_q <= 1'b0;
            wait_q     <= WLOAD;
            if (fend_q) begin
              mode_q  <= i_mode;
              alt_q   <= i_alt;
              en_q    <= i_en;
              state_q <= S_IDLE;
            end else begin
              state_q <= NXT_BYTE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  flash_addr_gen #(
    .H_BYTES(H_BYTES), .V_LINES(V_LINES), .ADDR_W(ADDR_W), .NUM_MODES(NUM_MODES),
    .WIN_X0(WIN_X0), .WIN_X1(WIN_X1), .WIN_Y0(WIN_Y0), .WIN_Y1(WIN_Y1),
    .ALT_BASE(ALT_BASE), .CW(CW), .RW(RW)
  ) u_addr_gen (
    .i_col  (col_q),
    .i_row  (row_q),
    .i_mode (mode_q),
    .i_alt  (alt_q),
    .o_addr (o_addr)
  );

  assign o_ce_n  = 1'b0;
  assign o_oe_n  = 1'b0;
  assign o_we_n  = 1'b1;
  assign o_rst_n = 1'b1;
  assign o_wp    = 1'b0;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_sof   = sof_q;
  assign o_eol   = eol_q;

endmodule
